// File: rtl/uart_tx_scheduler_if.sv
// Requester-side and uart_tx-side signal bundle for uart_tx_scheduler.
// master = scheduler, slave = requesters plus the attached uart_tx.
interface uart_tx_scheduler_if #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned GW         = $clog2(NREQ)
);
    logic [NREQ-1:0]            req_valid;
    logic [NREQ*WORD_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic [WORD_WIDTH-1:0]      din;
    logic                       tx_start;
    logic                       tx_done;
    logic                       tx_line;
    logic                       busy;
    logic [GW-1:0]              grant_id;

    modport master (
        input  req_valid, req_data, tx_done, tx_line,
        output req_ready, din, tx_start, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, tx_done, tx_line,
        input  req_ready, din, tx_start, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one uart_tx among NREQ requesters,
// optionally sending a tag word (MSB set, requester index in LSBs) before each data word.
module uart_tx_scheduler #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WORD_WIDTH = 8,
    parameter bit          TAG_EN     = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    uart_tx_scheduler_if.master bus
);
    localparam int unsigned GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BIT,
        WAIT_DONE
    } state_e;

    typedef enum logic {
        PH_TAG,
        PH_DATA
    } phase_e;

    state_e                state_q, state_d;
    phase_e                phase_q, phase_d;
    logic [WORD_WIDTH-1:0] din_q,   din_d;
    logic [WORD_WIDTH-1:0] hold_q,  hold_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         last_q,  last_d;
    logic                  done_q;

    logic                  done_rise;
    logic                  any_valid;
    logic [GW-1:0]         pick;
    logic [WORD_WIDTH-1:0] pick_word;
    logic [NREQ-1:0]       ready;

    function automatic logic [WORD_WIDTH-1:0] tag_word(input logic [GW-1:0] g);
        logic [WORD_WIDTH-1:0] t;
        t                 = '0;
        t[WORD_WIDTH-1]   = 1'b1;
        t[GW-1:0]         = g;
        return t;
    endfunction

    assign any_valid = |bus.req_valid;
    assign done_rise = bus.tx_done & ~done_q;
    assign pick_word = bus.req_data[32'(pick)*WORD_WIDTH +: WORD_WIDTH];

    // Round-robin: first valid requester strictly after last_q, wrapping.
    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        pick  = last_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = GW'((32'(last_q) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        din_d   = din_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        last_d  = last_q;
        ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    ready[pick] = 1'b1;
                    hold_d      = pick_word;
                    grant_d     = pick;
                    last_d      = pick;
                    state_d     = START;
                    if (TAG_EN) begin
                        phase_d = PH_TAG;
                        din_d   = tag_word(pick);
                    end else begin
                        phase_d = PH_DATA;
                        din_d   = pick_word;
                    end
                end
            end
            START: begin
                state_d = WAIT_BIT;
            end
            WAIT_BIT: begin
                if (!bus.tx_line) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    if (phase_q == PH_TAG) begin
                        phase_d = PH_DATA;
                        din_d   = hold_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= PH_TAG;
            din_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            last_q  <= GW'(NREQ - 1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            din_q   <= din_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done_q  <= bus.tx_done;
        end
    end

    // req_ready is a Mealy output of IDLE; masking with rst_n keeps it low while reset is held.
    assign bus.req_ready = rst_n ? ready : '0;
    assign bus.din       = din_q;
    assign bus.tx_start  = (state_q == START) || (state_q == WAIT_BIT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_q;
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one uart_tx (2..16).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, word width, equal to the attached uart_tx WORD_WIDTH.
REQ-003 SHALL have parameter TAG_EN, default 1; 1 = each data word is preceded by a tag word.
REQ-004 clk  input  1  single clock, shared with uart_tx.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester word-pending flag.
REQ-007 req_data  input  NREQ*WORD_WIDTH  requester i word at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-008 req_ready  output  NREQ  one-cycle pulse; the word of that requester is captured.
REQ-009 din  output  WORD_WIDTH  word to uart_tx, held stable for the whole frame.
REQ-010 tx_start  output  1  start request to uart_tx.
REQ-011 tx_done  input  1  uart_tx done level, high for 2^SHIFT cycles per frame.
REQ-012 tx_line  input  1  monitored uart_tx serial output, used for start-bit detection.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  clog2(NREQ)  index of the requester currently served.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_BIT, WAIT_DONE, with a phase flag (TAG/DATA).
REQ-016 IDLE: if any req_valid bit is set, SHALL grant round-robin, searching from last_grant+1 upward with wrap.
REQ-017 On grant, in the same cycle: req_ready[g] SHALL pulse; req_data slice SHALL be latched into hold_reg; grant_id SHALL take g; last_grant SHALL take g.
REQ-018 On grant, the next state SHALL be START with phase=TAG if TAG_EN=1, else phase=DATA.
REQ-019 Tag word SHALL be MSB=1, grant_id in LSBs, remaining bits 0 (NREQ=4, WW=8, g=2 gives 8'h82).
REQ-020 din SHALL present the tag word in phase TAG and hold_reg in phase DATA, registered and stable from entry to START until WAIT_DONE exits.
REQ-021 START: tx_start SHALL be 1; the state SHALL advance to WAIT_BIT at once.
REQ-022 WAIT_BIT: tx_start SHALL stay 1 until tx_line==0 is sampled, then SHALL drop to 0 in the next cycle; the state SHALL go to WAIT_DONE.
REQ-023 WAIT_DONE: SHALL wait for a rising edge of tx_done (registered previous value compared with current).
REQ-024 On that edge in phase TAG: SHALL go to START with phase=DATA.
REQ-025 On that edge in phase DATA: SHALL go to IDLE.
REQ-026 tx_start SHALL never be 1 in IDLE or WAIT_DONE.
REQ-027 Exactly one req_ready pulse per served word; req_ready SHALL be one-hot or zero.
REQ-028 A requester dropping req_valid after capture SHALL NOT affect the frame in flight.
REQ-029 New req_valid activity during a frame SHALL be ignored until IDLE.
REQ-030 Back-to-back: the earliest next grant is the cycle after the IDLE return; there SHALL be no idle gap beyond that.
REQ-031 With all requesters continuously valid, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation.
REQ-032 Single continuously valid requester SHALL be re-granted every transaction.

Reset
REQ-033 rst_n low SHALL asynchronously force: state IDLE, phase TAG, tx_start=0, req_ready=0, busy=0, din=0, grant_id=0, hold_reg=0, last_grant=NREQ-1, tx_done edge register=0.
REQ-034 Reset mid-frame SHALL abandon the transaction without a retry; the requester's word is lost because it was already acknowledged.
REQ-035 After deassertion, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-036 Reset, then req_valid=4'b0100 with data 8'h3C, TAG_EN=1 -> ready[2] pulses once; uart frames 8'h82 then 8'h3C; busy drops after the second tx_done rise.
REQ-037 req_valid=4'b1111 held, data i=8'h10+i -> tag/data pairs in order 80/10, 81/11, 82/12, 83/13, 80/10.
REQ-038 TAG_EN=0, req_valid=4'b0001, data 8'hA5 repeated -> back-to-back 8'hA5 frames; tx_start goes high once per frame and falls one cycle after tx_line low.
REQ-039 SHIFT=2, STOP_BITS=2 uart -> tx_done high 4 cycles counts as one edge; no frame is duplicated or dropped; din is stable across each frame.
REQ-040 rst_n pulsed low mid-data-frame -> all outputs reach reset values asynchronously; the next request after release is served normally.
REQ-041 req_valid[1] asserted for exactly the grant cycle only -> word captured and sent complete; no second ready pulse.
